// File: rtl/ysyx_220066_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the stage FSM encoding, the MemOp size encodings and two helpers
// (alignment check and store byte-mask) used by the stage top.
package ysyx_220066_mem_pkg;

    // IDLE: empty slot or non-memory op, REQ: bus request outstanding,
    // HOLD: memory result ready and waiting for WB to take it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_e;

    // MemOp[1:0] access sizes; MemOp[2] set means an unsigned load
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // An access is misaligned when the low address bits below its size are non-zero
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = a[0];
            SIZE_W:  mis = |a[1:0];
            default: mis = |a;
        endcase
        return mis;
    endfunction

    // Byte-write mask for a store of the given size at byte lane a
    function automatic logic [7:0] store_mask(input logic [1:0] size, input logic [2:0] a);
        logic [7:0] m;
        m = 8'h00;
        case (size)
            SIZE_B:  m = 8'h01 << a;
            SIZE_H:  m = 8'h03 << a;
            SIZE_W:  m = 8'h0f << a;
            default: m = 8'hff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_220066_mem_LoadExt.sv
// Load data extraction for the MEM stage.
// Picks the addressed lane out of the 8-byte bus word and sign- or
// zero-extends it to 64 bits.
//   rdata   in   64  raw bus read data (8-byte aligned word)
//   addr_lo in   3   byte offset of the access within the word
//   mem_op  in   3   [1:0] size, [2] unsigned
//   result  out  64  extended load value
module ysyx_220066_mem_LoadExt
    import ysyx_220066_mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr_lo,
    input  logic [2:0]  mem_op,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Move the addressed byte lane down to bit 0, then extend by size.
    // Doublewords are always aligned, so their shift amount is zero.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = shifted;
        case (mem_op[1:0])
            SIZE_B:  result = mem_op[2] ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = mem_op[2] ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            SIZE_W:  result = mem_op[2] ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_mem.sv
// MEM pipeline stage: registers the EX slot, runs one req/ack bus access
// per load/store, and presents the writeback value to WB.
//   clk, rst            clock, synchronous active-high reset
//   block               WB stall: hold stage contents
//   valid_in .. rd_in   EX slot (pc, ALU result/address, store data, MemOp, flags, rd)
//   busy                stage waiting on the bus; EX must hold
//   mem_req/wen/addr/wdata/wmask   bus request side
//   mem_ack/rdata/err   bus response side (one-cycle ack)
//   valid, error, RegWr, pc, rd, data   slot presented to WB
// The bus is 8 bytes wide, so XLEN is expected to be 64.
module ysyx_220066_mem
    import ysyx_220066_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            block,
    input  logic            valid_in,
    input  logic            error_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] src2_in,
    input  logic [2:0]      MemOp_in,
    input  logic            MemRd_in,
    input  logic            MemWr_in,
    input  logic            RegWr_in,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            mem_req,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err,
    output logic            valid,
    output logic            error,
    output logic            RegWr,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] data
);

    localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = (ACK_TIMEOUT == 0) ? 16'd0 : 16'(ACK_TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic            regwr_q, regwr_d;
    logic            memrd_q, memrd_d;
    logic            memwr_q, memwr_d;
    logic [2:0]      memop_q, memop_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            ld;
    logic            mem_op_in;
    logic            mis_in;
    logic [XLEN-1:0] load_val;

    ysyx_220066_mem_LoadExt u_load_ext (
        .rdata   (mem_rdata),
        .addr_lo (result_q[2:0]),
        .mem_op  (memop_q),
        .result  (load_val)
    );

    // Next-state logic. A new EX slot is taken whenever WB is not stalling
    // and no bus access is outstanding; while in REQ the captured slot is
    // frozen so the bus sees stable address/data until ack or timeout.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        error_d  = error_q;
        regwr_d  = regwr_q;
        memrd_d  = memrd_q;
        memwr_d  = memwr_q;
        memop_d  = memop_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        result_d = result_q;
        src2_d   = src2_q;
        data_d   = data_q;
        cnt_d    = cnt_q;

        ld        = ~block & (state_q != ST_REQ);
        mem_op_in = MemRd_in | MemWr_in;
        mis_in    = is_misaligned(MemOp_in[1:0], result_in[2:0]);

        if (ld) begin
            valid_d  = valid_in;
            regwr_d  = RegWr_in;
            memrd_d  = MemRd_in;
            memwr_d  = MemWr_in;
            memop_d  = MemOp_in;
            rd_d     = rd_in;
            pc_d     = pc_in;
            result_d = result_in;
            src2_d   = src2_in;
            data_d   = result_in;
            cnt_d    = 16'd0;
            // Faulty or misaligned accesses never reach the bus
            error_d  = error_in | (valid_in & mem_op_in & mis_in);
            state_d  = (valid_in & mem_op_in & ~error_in & ~mis_in) ? ST_REQ : ST_IDLE;
        end else if (state_q == ST_REQ) begin
            if (mem_ack) begin
                data_d  = memrd_q ? load_val : result_q;
                error_d = error_q | mem_err;
                state_d = ST_HOLD;
            end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                error_d = 1'b1;
                state_d = ST_HOLD;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Stage registers with synchronous reset; resetting while in REQ drops
    // the request on the same edge, so a late ack finds the stage in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            regwr_q  <= 1'b0;
            memrd_q  <= 1'b0;
            memwr_q  <= 1'b0;
            memop_q  <= 3'd0;
            rd_q     <= 5'd0;
            pc_q     <= '0;
            result_q <= '0;
            src2_q   <= '0;
            data_q   <= '0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            regwr_q  <= regwr_d;
            memrd_q  <= memrd_d;
            memwr_q  <= memwr_d;
            memop_q  <= memop_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            src2_q   <= src2_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    // Bus and WB outputs. Store data is replicated into every lane so the
    // byte mask alone selects what the slave writes.
    always_comb begin
        mem_req   = (state_q == ST_REQ);
        busy      = (state_q == ST_REQ);
        mem_wen   = memwr_q;
        mem_addr  = {result_q[XLEN-1:3], 3'b000};
        mem_wmask = memwr_q ? store_mask(memop_q[1:0], result_q[2:0]) : 8'h00;
        case (memop_q[1:0])
            SIZE_B:  mem_wdata = {8{src2_q[7:0]}};
            SIZE_H:  mem_wdata = {4{src2_q[15:0]}};
            SIZE_W:  mem_wdata = {2{src2_q[31:0]}};
            default: mem_wdata = src2_q;
        endcase
        valid = valid_q & (state_q != ST_REQ);
        error = error_q;
        RegWr = regwr_q;
        pc    = pc_q;
        rd    = rd_q;
        data  = data_q;
    end

endmodule

// File: tb/tb_ysyx_220066_mem.sv
// Self-checking bench for the MEM stage: directed scenarios plus a
// randomized run, compared against a byte-level behavioural model.
module tb_ysyx_220066_mem;

    logic        clk;
    logic        rst;
    logic        block;
    logic        valid_in;
    logic        error_in;
    logic [63:0] pc_in;
    logic [63:0] result_in;
    logic [63:0] src2_in;
    logic [2:0]  MemOp_in;
    logic        MemRd_in;
    logic        MemWr_in;
    logic        RegWr_in;
    logic [4:0]  rd_in;
    logic        busy;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        valid;
    logic        error;
    logic        RegWr;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;

    int checks = 0;
    int errors = 0;

    ysyx_220066_mem #(
        .XLEN        (64),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .block     (block),
        .valid_in  (valid_in),
        .error_in  (error_in),
        .pc_in     (pc_in),
        .result_in (result_in),
        .src2_in   (src2_in),
        .MemOp_in  (MemOp_in),
        .MemRd_in  (MemRd_in),
        .MemWr_in  (MemWr_in),
        .RegWr_in  (RegWr_in),
        .rd_in     (rd_in),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .valid     (valid),
        .error     (error),
        .RegWr     (RegWr),
        .pc        (pc),
        .rd        (rd),
        .data      (data)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes from MemOp
    function automatic int sizeBytes(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    // Reference model: load value from bus word, byte lane a
    function automatic logic [63:0] modelLoad(input logic [63:0] word, input logic [2:0] a,
                                              input logic [2:0] op);
        int          n;
        logic [63:0] m;
        logic [63:0] v;
        n = sizeBytes(op);
        m = (n == 8) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << (8 * n)) - 64'd1);
        v = (word >> (8 * int'(a))) & m;
        if (!op[2] && n < 8 && v[8 * n - 1])
            v = v | ~m;
        return v;
    endfunction

    // Reference model: byte-write mask
    function automatic logic [7:0] modelMask(input logic [2:0] op, input logic [2:0] a);
        int m;
        m = ((1 << sizeBytes(op)) - 1) << int'(a);
        return m[7:0];
    endfunction

    // Reference model: every byte i of the bus word carries store byte (i mod size)
    function automatic logic [63:0] modelWdata(input logic [2:0] op, input logic [63:0] s);
        logic [63:0] w;
        int          n;
        n = sizeBytes(op);
        w = '0;
        for (int i = 0; i < 8; i++)
            w[8 * i +: 8] = s[8 * (i % n) +: 8];
        return w;
    endfunction

    task automatic idleInputs();
        valid_in  = 1'b0;
        error_in  = 1'b0;
        MemRd_in  = 1'b0;
        MemWr_in  = 1'b0;
        RegWr_in  = 1'b0;
        MemOp_in  = 3'd0;
        rd_in     = 5'd0;
        pc_in     = '0;
        result_in = '0;
        src2_in   = '0;
    endtask

    // Present one EX slot and let the stage capture it; returns on the next falling edge
    task automatic applyStimulus(input logic [63:0] pcV, input logic [63:0] addrV,
                                 input logic [63:0] src2V, input logic [2:0] opV,
                                 input bit ldV, input bit stV, input logic [4:0] rdV,
                                 input bit errV);
        valid_in  = 1'b1;
        error_in  = errV;
        pc_in     = pcV;
        result_in = addrV;
        src2_in   = src2V;
        MemOp_in  = opV;
        MemRd_in  = ldV;
        MemWr_in  = stV;
        RegWr_in  = !stV;
        rd_in     = rdV;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction with block low, checked against the model.
    // While the request is outstanding a different EX slot is offered to
    // confirm the stage does not take it.
    task automatic runTxn(input logic [63:0] pcV, input logic [63:0] addrV,
                          input logic [63:0] src2V, input logic [2:0] opV,
                          input bit ldV, input bit stV, input bit errV,
                          input logic [4:0] rdV, input int delayV,
                          input logic [63:0] rdataV, input bit merrV);
        bit isMem;
        bit mis;
        bit expReq;
        bit expErr;
        isMem  = ldV || stV;
        mis    = (int'(addrV[2:0]) % sizeBytes(opV)) != 0;
        expReq = isMem && !errV && !mis;
        expErr = errV || (isMem && mis);
        applyStimulus(pcV, addrV, src2V, opV, ldV, stV, rdV, errV);
        checkOutput("mem_req", mem_req, expReq);
        checkOutput("busy", busy, expReq);
        if (expReq) begin
            checkOutput("valid_in_req", valid, 1'b0);
            checkOutput("mem_addr", mem_addr, addrV & ~64'd7);
            checkOutput("mem_wen", mem_wen, stV);
            checkOutput("mem_wmask", mem_wmask, stV ? modelMask(opV, addrV[2:0]) : 8'h00);
            if (stV)
                checkOutput("mem_wdata", mem_wdata, modelWdata(opV, src2V));
            valid_in  = 1'b1;
            MemRd_in  = 1'b1;
            pc_in     = ~pcV;
            result_in = addrV ^ 64'h100;
            for (int i = 0; i < delayV; i++) begin
                @(negedge clk);
                checkOutput("req_held", mem_req, 1'b1);
                checkOutput("addr_stable", mem_addr, addrV & ~64'd7);
                checkOutput("busy_held", busy, 1'b1);
            end
            mem_ack   = 1'b1;
            mem_rdata = rdataV;
            mem_err   = merrV;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            checkOutput("done_req", mem_req, 1'b0);
            checkOutput("done_busy", busy, 1'b0);
            checkOutput("done_valid", valid, 1'b1);
            checkOutput("done_error", error, merrV);
            checkOutput("done_data", data, ldV ? modelLoad(rdataV, addrV[2:0], opV) : addrV);
        end else begin
            checkOutput("pass_valid", valid, 1'b1);
            checkOutput("pass_error", error, expErr);
            checkOutput("pass_data", data, addrV);
        end
        checkOutput("RegWr", RegWr, !stV);
        checkOutput("rd", rd, rdV);
        checkOutput("pc", pc, pcV);
    endtask

    initial begin
        int          cnt;
        int          kind;
        int          n;
        logic [2:0]  op;
        logic [63:0] addr;

        rst       = 1'b1;
        block     = 1'b0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        idleInputs();
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_valid", valid, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_RegWr", RegWr, 1'b0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_mem_wen", mem_wen, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wmask", mem_wmask, 8'h00);
        checkOutput("rst_data", data, 64'd0);
        rst = 1'b0;

        // lw, ack in the first REQ cycle, sign-extended upper word
        runTxn(64'h8000_1000, 64'h8000_0004, 64'd0, 3'b010, 1'b1, 1'b0, 1'b0, 5'd3, 0,
               64'h8000_0001_0000_0000, 1'b0);
        checkOutput("lw_data", data, 64'hFFFF_FFFF_8000_0001);

        // sb to byte lane 3
        runTxn(64'h8000_1004, 64'h8000_0003, 64'h0000_0000_0000_00AB, 3'b000, 1'b0, 1'b1,
               1'b0, 5'd0, 0, 64'd0, 1'b0);

        // ld with a five-cycle ack delay
        runTxn(64'h8000_1008, 64'h8000_0010, 64'd0, 3'b011, 1'b1, 1'b0, 1'b0, 5'd7, 5,
               64'h1234_5678_9ABC_DEF0, 1'b0);

        // misaligned lh: flagged, never reaches the bus
        runTxn(64'h8000_100C, 64'h8000_0001, 64'd0, 3'b001, 1'b1, 1'b0, 1'b0, 5'd9, 0,
               64'd0, 1'b0);

        // Bus error acknowledged while WB is stalling
        applyStimulus(64'h8000_2000, 64'h8000_0020, 64'd0, 3'b011, 1'b1, 1'b0, 5'd4, 1'b0);
        checkOutput("blk_req", mem_req, 1'b1);
        block     = 1'b1;
        mem_ack   = 1'b1;
        mem_err   = 1'b1;
        pc_in     = 64'hDEAD_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("blk_error", error, 1'b1);
            checkOutput("blk_valid", valid, 1'b1);
            checkOutput("blk_req_low", mem_req, 1'b0);
            checkOutput("blk_pc", pc, 64'h8000_2000);
            @(negedge clk);
        end
        block = 1'b0;
        idleInputs();
        @(negedge clk);
        checkOutput("blk_release_valid", valid, 1'b0);
        checkOutput("blk_release_error", error, 1'b0);

        // Reset while a request is outstanding, then a stray ack
        applyStimulus(64'h8000_3000, 64'h8000_0040, 64'd0, 3'b011, 1'b1, 1'b0, 5'd5, 1'b0);
        checkOutput("rstreq_req", mem_req, 1'b1);
        idleInputs();
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rstreq_valid", valid, 1'b0);
        checkOutput("rstreq_mem_req", mem_req, 1'b0);
        checkOutput("rstreq_busy", busy, 1'b0);

        // No ack at all: request is abandoned after the timeout
        applyStimulus(64'h8000_4000, 64'h8000_0080, 64'd0, 3'b011, 1'b1, 1'b0, 5'd6, 1'b0);
        idleInputs();
        cnt = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("timeout_cycles", 64'(cnt), 64'd8);
        checkOutput("timeout_error", error, 1'b1);
        checkOutput("timeout_valid", valid, 1'b1);
        @(negedge clk);

        // Randomized mix of ALU ops, loads and stores
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            op   = 3'($urandom_range(0, 7));
            n    = sizeBytes(op);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                addr[2:0] = addr[2:0] & ~3'(n - 1);
            runTxn({$urandom, $urandom}, addr, {$urandom, $urandom}, op,
                   kind == 1, kind == 2, $urandom_range(0, 9) == 0,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3),
                   {$urandom, $urandom}, $urandom_range(0, 4) == 0);
        end

        idleInputs();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
